// File: rtl/appr_mul_arbiter.sv
// rtl/appr_mul_arbiter.sv - round-robin arbiter sharing one approximate signed multiplier

// Baugh-Wooley 9x9 signed multiplier with per-operation approximation.
// appr_mask[j] drops partial-product row j (magnitude bit j of b);
// res_mask gates the upper N_BIT_RES result bits, the lower bits always pass.
module mul_9x9_signed_bw #(
  parameter int N_BIT_RES  = 14,
  parameter int N_BIT_APPR = 8
) (
  input  logic [8:0]            a,
  input  logic [8:0]            b,
  input  logic [N_BIT_RES-1:0]  res_mask,
  input  logic [N_BIT_APPR-1:0] appr_mask,
  output logic [17:0]           p
);

  logic [7:0]  appr8;
  logic [17:0] keep;
  logic [8:0]  be;
  logic [17:0] acc;

  // Masks wider than the array are ignored; narrower ones leave bits untouched.
  for (genvar j = 0; j < 8; j++) begin : g_appr
    if (j < N_BIT_APPR) begin : g_use
      assign appr8[j] = appr_mask[j];
    end else begin : g_zero
      assign appr8[j] = 1'b0;
    end
  end

  for (genvar k = 0; k < 18; k++) begin : g_keep
    if (k >= 18 - N_BIT_RES) begin : g_use
      assign keep[k] = res_mask[k-(18-N_BIT_RES)];
    end else begin : g_one
      assign keep[k] = 1'b1;
    end
  end

  assign be = b & ~{1'b0, appr8};

  // Partial-product array: positive core, inverted sign rows, constant 2^17 + 2^9.
  always_comb begin
    acc = 18'h20200;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        acc = acc + ({17'b0, a[i] & be[j]} << (i + j));
      end
    end
    for (int k = 0; k < 8; k++) begin
      acc = acc + ({17'b0, ~(a[8] & be[k])} << (8 + k));
      acc = acc + ({17'b0, ~(a[k] & be[8])} << (8 + k));
    end
    acc = acc + ({17'b0, a[8] & be[8]} << 16);
    p   = acc & keep;
  end

endmodule

module appr_mul_arbiter #(
  parameter  int N_REQ      = 4,
  parameter  int N_BIT_RES  = 14,
  parameter  int N_BIT_APPR = 8,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*9-1:0]          req_a,
  input  logic [N_REQ*9-1:0]          req_b,
  input  logic [N_REQ*N_BIT_RES-1:0]  req_res_mask,
  input  logic [N_REQ*N_BIT_APPR-1:0] req_appr_mask,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [17:0]                 resp_data,
  output logic [ID_W-1:0]             resp_id,
  output logic                        busy
);

  logic [ID_W-1:0]       rr_ptr;
  logic [8:0]            s1_a, s1_b;
  logic [N_BIT_RES-1:0]  s1_res;
  logic [N_BIT_APPR-1:0] s1_appr;
  logic [ID_W-1:0]       s1_id;
  logic                  v1;
  logic [17:0]           s2_data;
  logic [ID_W-1:0]       s2_id;
  logic                  v2;

  logic                  adv;
  logic                  gnt_found;
  logic [ID_W-1:0]       gnt_idx;
  logic [ID_W-1:0]       cand_id;
  int                    cand;
  logic                  hs;
  logic [8:0]            sel_a, sel_b;
  logic [N_BIT_RES-1:0]  sel_res;
  logic [N_BIT_APPR-1:0] sel_appr;
  logic [17:0]           mul_p;

  assign adv = !v2 || resp_ready;

  // Round-robin search beginning just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_id   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand    = (int'(rr_ptr) + off) % N_REQ;
      cand_id = ID_W'(cand);
      if (!gnt_found && req_valid[cand_id]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_id;
      end
    end
  end

  // Grant is only offered when the pipeline can move and reset is released.
  always_comb begin
    req_ready = '0;
    if (adv && !rst && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign hs = |req_ready;

  // Field mux for the granted requester.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_res  = '0;
    sel_appr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a    = req_a[i*9 +: 9];
        sel_b    = req_b[i*9 +: 9];
        sel_res  = req_res_mask[i*N_BIT_RES +: N_BIT_RES];
        sel_appr = req_appr_mask[i*N_BIT_APPR +: N_BIT_APPR];
      end
    end
  end

  mul_9x9_signed_bw #(
    .N_BIT_RES  (N_BIT_RES),
    .N_BIT_APPR (N_BIT_APPR)
  ) u_mul (
    .a         (s1_a),
    .b         (s1_b),
    .res_mask  (s1_res),
    .appr_mask (s1_appr),
    .p         (mul_p)
  );

  // Two-stage pipeline and round-robin pointer; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= ID_W'(N_REQ - 1);
      s1_a    <= '0;
      s1_b    <= '0;
      s1_res  <= '0;
      s1_appr <= '0;
      s1_id   <= '0;
      v1      <= 1'b0;
      s2_data <= '0;
      s2_id   <= '0;
      v2      <= 1'b0;
    end else if (adv) begin
      s2_data <= mul_p;
      s2_id   <= s1_id;
      v2      <= v1;
      if (hs) begin
        s1_a    <= sel_a;
        s1_b    <= sel_b;
        s1_res  <= sel_res;
        s1_appr <= sel_appr;
        s1_id   <= gnt_idx;
        v1      <= 1'b1;
        rr_ptr  <= gnt_idx;
      end else begin
        v1 <= 1'b0;
      end
    end
  end

  assign resp_valid = v2;
  assign resp_data  = s2_data;
  assign resp_id    = s2_id;
  assign busy       = v1 || v2;

endmodule

// File: tb/tb_appr_mul_arbiter.sv
// tb/tb_appr_mul_arbiter.sv - self-checking bench for appr_mul_arbiter
module tb_appr_mul_arbiter;

  localparam int N  = 4;
  localparam int NR = 14;
  localparam int NA = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*9-1:0]  req_a, req_b;
  logic [N*NR-1:0] req_res_mask;
  logic [N*NA-1:0] req_appr_mask;
  logic            resp_valid, resp_ready;
  logic [17:0]     resp_data;
  logic [IW-1:0]   resp_id;
  logic            busy;

  appr_mul_arbiter #(.N_REQ(N), .N_BIT_RES(NR), .N_BIT_APPR(NA)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_res_mask(req_res_mask),
    .req_appr_mask(req_appr_mask), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: two's-complement product of a and b with masked magnitude bits of b.
  int          last;
  logic        m1_v, m2_v;
  int          m1_id, m2_id;
  logic [17:0] m1_d, m2_d;
  int          grant_q[$];
  int          resp_q[$];
  int          last_g;
  int          n_hs, n_resp;

  function automatic logic [17:0] ref_mul(logic [8:0] a, logic [8:0] b,
                                          logic [NR-1:0] rm, logic [NA-1:0] am);
    logic [8:0]  be;
    int          p;
    logic [17:0] r;
    be = b & ~{1'b0, am};
    p  = $signed(a) * $signed(be);
    r  = p[17:0];
    return r & {rm, 4'hF};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [8:0] a, input logic [8:0] b,
                         input logic [NR-1:0] rm, input logic [NA-1:0] am);
    req_a[i*9 +: 9]           = a;
    req_b[i*9 +: 9]           = b;
    req_res_mask[i*NR +: NR]  = rm;
    req_appr_mask[i*NA +: NA] = am;
  endtask

  // One clock: check outputs against the model, take the edge, advance the model.
  task automatic tick();
    logic       adv;
    int         g, c;
    logic [N-1:0] exp_rdy;
    #1;
    adv = !m2_v || resp_ready;
    g   = -1;
    if (adv && !rst) begin
      for (int off = 1; off <= N; off++) begin
        c = (last + off) % N;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("resp_valid", 32'(resp_valid), 32'(m2_v));
    check("busy", 32'(busy), 32'(m1_v || m2_v));
    if (m2_v) begin
      check("resp_id", 32'(resp_id), 32'(m2_id));
      check("resp_data", 32'(resp_data), 32'(m2_d));
    end
    last_g = g;
    if (g >= 0 && !rst) begin
      grant_q.push_back(g);
      n_hs++;
    end
    if (m2_v && resp_ready && !rst) begin
      resp_q.push_back(m2_id);
      n_resp++;
    end
    @(posedge clk);
    if (rst) begin
      m1_v = 1'b0; m2_v = 1'b0; last = N - 1;
    end else if (adv) begin
      m2_v = m1_v; m2_id = m1_id; m2_d = m1_d;
      m1_v = (g >= 0);
      if (g >= 0) begin
        m1_id = g;
        m1_d  = ref_mul(req_a[g*9 +: 9], req_b[g*9 +: 9],
                        req_res_mask[g*NR +: NR], req_appr_mask[g*NA +: NA]);
        last  = g;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  logic [17:0] hold_d;
  logic [IW-1:0] hold_id;
  int base_hs, base_resp;

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = 1'b1;
    req_a = '0; req_b = '0; req_res_mask = '0; req_appr_mask = '0;
    m1_v = 0; m2_v = 0; m1_id = 0; m2_id = 0; m1_d = 0; m2_d = 0;
    last = N - 1; n_hs = 0; n_resp = 0; last_g = -1;
    @(posedge clk); #1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single request from requester 0: -3 * 5 = -15.
    set_req(0, 9'h1FD, 9'h005, 14'h3FFF, 8'h00);
    req_valid = 4'b0001;
    tick();
    check("single_grant", 32'(last_g), 32'd0);
    req_valid = '0;
    check("single_busy_s1", 32'(busy), 32'd1);
    tick();
    check("single_lat_valid", 32'(resp_valid), 32'd1);
    check("single_lat_data", 32'(resp_data), 32'h3FFF1);
    check("single_lat_id", 32'(resp_id), 32'd0);
    tick();
    tick();
    check("single_idle", 32'(busy), 32'd0);

    // Contention: all four requesting with distinct fields.
    do_reset();
    set_req(0, 9'h07F, 9'h1F0, 14'h3FF0, 8'h01);
    set_req(1, 9'h100, 9'h0FF, 14'h3FFF, 8'h0F);
    set_req(2, 9'h0A5, 9'h133, 14'h2AAA, 8'h80);
    set_req(3, 9'h1FF, 9'h1FF, 14'h1FFF, 8'h00);
    grant_q.delete(); resp_q.delete();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) tick();
    req_valid = '0;
    for (int k = 0; k < 3; k++) tick();
    for (int k = 0; k < 5; k++) check("cont_grant", 32'(grant_q[k]), 32'(k % N));
    for (int k = 0; k < 4; k++) check("cont_resp_id", 32'(resp_q[k]), 32'(k));

    // Round-robin wrap: grant 2, then 0 and 2 alternate.
    grant_q.delete();
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) tick();
    req_valid = '0;
    check("rr_g0", 32'(grant_q[0]), 32'd2);
    check("rr_g1", 32'(grant_q[1]), 32'd0);
    check("rr_g2", 32'(grant_q[2]), 32'd2);
    check("rr_g3", 32'(grant_q[3]), 32'd0);
    check("rr_g4", 32'(grant_q[4]), 32'd2);
    for (int k = 0; k < 3; k++) tick();

    // Backpressure: stall three cycles at the first response.
    base_hs = n_hs; base_resp = n_resp;
    req_valid = 4'b1111;
    tick();
    tick();
    resp_ready = 1'b0;
    hold_d = resp_data; hold_id = resp_id;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_data", 32'(resp_data), 32'(hold_d));
      check("bp_id", 32'(resp_id), 32'(hold_id));
    end
    resp_ready = 1'b1;
    tick();
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) tick();
    check("bp_balance", 32'(n_resp - base_resp), 32'(n_hs - base_hs));

    // Mid-operation reset with two entries in flight.
    req_valid = 4'b0010;
    tick();
    tick();
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = '0;
    check("mid_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_resp_data", 32'(resp_data), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    req_valid = 4'b1111;
    tick();
    check("mid_first_grant", 32'(last_g), 32'd0);
    req_valid = '0;
    for (int k = 0; k < 3; k++) tick();

    // Random soak honouring the hold-until-ready rule.
    base_hs = n_hs; base_resp = n_resp;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, 9'($urandom), 9'($urandom), NR'($urandom), NA'($urandom));
          req_valid[i] = 1'b1;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_g >= 0) req_valid[last_g] = 1'b0;
    end
    req_valid = '0;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("soak_balance", 32'(n_resp - base_resp), 32'(n_hs - base_hs));
    check("soak_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
